// File: rtl/ibex_lsu_resp_unit.sv
// ibex_lsu_resp_unit
// Data-side load/store unit feeding the writeback stage. Accepts one access at a time, issues it on
// a req/gnt/rvalid data bus, splits misaligned accesses into two word transactions and returns
// aligned, extended load data with a one-cycle response strobe.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   lsu_req_i / lsu_ready_o         request handshake from ID/EX (accept = req & ready)
//   lsu_we_i, lsu_type_i,           store flag, size (00 word, 01 half, 1x byte), sign extension,
//   lsu_sign_ext_i, lsu_addr_i,     byte address and LSB-aligned store data
//   lsu_wdata_i
//   data_req_o .. data_wdata_o      bus request side (held stable until data_gnt_i)
//   data_gnt_i, data_rvalid_i,      bus grant and response side
//   data_rdata_i, data_err_i
//   rf_wdata_lsu_o, rf_we_lsu_o     load result for the register file
//   lsu_resp_valid_o, lsu_resp_err_o final response pulse and its error flag

module ibex_lsu_resp_unit #(
    parameter bit MisalignedSupport = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StGnt1,
        StResp1,
        StGnt2,
        StResp2,
        StMisErr
    } state_t;

    state_t      state;
    logic [1:0]  offset;
    logic [1:0]  acc_type;
    logic        acc_we;
    logic        acc_sext;
    logic        split;
    logic [29:0] word_addr;
    logic [31:0] wdata_rot;
    logic [31:0] rdata1;

    // Request-side decode, only meaningful in the accept cycle
    logic [1:0]  req_type;
    logic        req_mis;
    logic [31:0] req_wdata_rot;

    // Type 11 behaves as byte
    assign req_type = (lsu_type_i == 2'b11) ? 2'b10 : lsu_type_i;

    always_comb begin
        req_mis = 1'b0;
        case (req_type)
            2'b00:   req_mis = (lsu_addr_i[1:0] != 2'b00);
            2'b01:   req_mis = (lsu_addr_i[1:0] == 2'b11);
            default: req_mis = 1'b0;
        endcase
    end

    always_comb begin
        req_wdata_rot = lsu_wdata_i;
        case (lsu_addr_i[1:0])
            2'd0:    req_wdata_rot = lsu_wdata_i;
            2'd1:    req_wdata_rot = {lsu_wdata_i[23:0], lsu_wdata_i[31:24]};
            2'd2:    req_wdata_rot = {lsu_wdata_i[15:0], lsu_wdata_i[31:16]};
            default: req_wdata_rot = {lsu_wdata_i[7:0], lsu_wdata_i[31:8]};
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= StIdle;
            offset    <= 2'b00;
            acc_type  <= 2'b00;
            acc_we    <= 1'b0;
            acc_sext  <= 1'b0;
            split     <= 1'b0;
            word_addr <= 30'h0;
            wdata_rot <= 32'h0;
            rdata1    <= 32'h0;
        end else begin
            case (state)
                StIdle: begin
                    if (lsu_req_i) begin
                        offset    <= lsu_addr_i[1:0];
                        acc_type  <= req_type;
                        acc_we    <= lsu_we_i;
                        acc_sext  <= lsu_sign_ext_i;
                        split     <= req_mis;
                        word_addr <= lsu_addr_i[31:2];
                        wdata_rot <= req_wdata_rot;
                        // Without split support a misaligned access never reaches the bus
                        state     <= (req_mis && !MisalignedSupport) ? StMisErr : StGnt1;
                    end
                end
                StGnt1: begin
                    if (data_gnt_i) state <= StResp1;
                end
                StResp1: begin
                    if (data_rvalid_i) begin
                        if (split && !data_err_i) begin
                            rdata1 <= data_rdata_i;
                            state  <= StGnt2;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                StGnt2: begin
                    if (data_gnt_i) state <= StResp2;
                end
                StResp2: begin
                    if (data_rvalid_i) state <= StIdle;
                end
                StMisErr: state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

    // Bus request side
    logic       in_req;
    logic       part2;
    logic [3:0] be_part1;
    logic [3:0] be_part2;

    assign in_req = (state == StGnt1) || (state == StGnt2);
    assign part2  = (state == StGnt2);

    always_comb begin
        be_part1 = 4'b0000;
        case (acc_type)
            2'b00:   be_part1 = 4'b1111 << offset;
            2'b01:   be_part1 = (offset == 2'd3) ? 4'b1000 : (4'b0011 << offset);
            default: be_part1 = 4'b0001 << offset;
        endcase
    end

    // Part 2 only exists for split word (offset 1..3) or half at offset 3
    assign be_part2 = (acc_type == 2'b00) ? (4'b1111 >> (3'd4 - {1'b0, offset})) : 4'b0001;

    assign lsu_ready_o  = (state == StIdle);
    assign data_req_o   = in_req;
    assign data_addr_o  = in_req ? {(part2 ? word_addr + 30'd1 : word_addr), 2'b00} : 32'h0;
    assign data_we_o    = in_req & acc_we;
    assign data_be_o    = in_req ? (part2 ? be_part2 : be_part1) : 4'b0000;
    assign data_wdata_o = in_req ? wdata_rot : 32'h0;

    // Response side
    logic        final_rvalid;
    logic [4:0]  sh_lo;
    logic [5:0]  sh_hi;
    logic [31:0] raw;
    logic [31:0] ext;

    assign final_rvalid = data_rvalid_i &
                          (((state == StResp1) & (~split | data_err_i)) | (state == StResp2));
    assign sh_lo = {offset, 3'b000};
    assign sh_hi = 6'd32 - {1'b0, offset, 3'b000};

    always_comb begin
        raw = 32'h0;
        if (state == StResp2) begin
            if (acc_type == 2'b00) begin
                raw = (data_rdata_i << sh_hi) | (rdata1 >> sh_lo);
            end else begin
                raw = {16'h0, data_rdata_i[7:0], rdata1[31:24]};
            end
        end else begin
            raw = data_rdata_i >> sh_lo;
        end
    end

    always_comb begin
        ext = raw;
        case (acc_type)
            2'b00:   ext = raw;
            2'b01:   ext = {{16{acc_sext & raw[15]}}, raw[15:0]};
            default: ext = {{24{acc_sext & raw[7]}}, raw[7:0]};
        endcase
    end

    assign lsu_resp_valid_o = final_rvalid | (state == StMisErr);
    assign lsu_resp_err_o   = (final_rvalid & data_err_i) | (state == StMisErr);
    assign rf_we_lsu_o      = lsu_resp_valid_o & ~acc_we & ~lsu_resp_err_o;
    assign rf_wdata_lsu_o   = rf_we_lsu_o ? ext : 32'h0;

endmodule

// File: tb/tb_ibex_lsu_resp_unit.sv
// Testbench for ibex_lsu_resp_unit: a byte-level reference model predicts bus transactions and
// load results; a small bus responder applies grant/response delays.

module tb_ibex_lsu_resp_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        lsu_req, m_req;
    logic        lsu_we, lsu_sext;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        gnt, rvalid, derr;
    logic [31:0] rdata;

    logic        ready, data_req, data_we, rf_we, resp_valid, resp_err;
    logic [31:0] data_addr, data_wdata, rf_wdata;
    logic [3:0]  data_be;

    logic        m_ready, m_data_req, m_data_we, m_rf_we, m_resp_valid, m_resp_err;
    logic [31:0] m_data_addr, m_data_wdata, m_rf_wdata;
    logic [3:0]  m_data_be;

    ibex_lsu_resp_unit #(.MisalignedSupport(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(lsu_req), .lsu_ready_o(ready),
        .lsu_we_i(lsu_we), .lsu_type_i(lsu_type), .lsu_sign_ext_i(lsu_sext),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .data_req_o(data_req),
        .data_gnt_i(gnt), .data_addr_o(data_addr), .data_we_o(data_we), .data_be_o(data_be),
        .data_wdata_o(data_wdata), .data_rvalid_i(rvalid), .data_rdata_i(rdata),
        .data_err_i(derr), .rf_wdata_lsu_o(rf_wdata), .rf_we_lsu_o(rf_we),
        .lsu_resp_valid_o(resp_valid), .lsu_resp_err_o(resp_err)
    );

    ibex_lsu_resp_unit #(.MisalignedSupport(1'b0)) dut_nomis (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(m_req), .lsu_ready_o(m_ready),
        .lsu_we_i(lsu_we), .lsu_type_i(lsu_type), .lsu_sign_ext_i(lsu_sext),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .data_req_o(m_data_req),
        .data_gnt_i(gnt), .data_addr_o(m_data_addr), .data_we_o(m_data_we),
        .data_be_o(m_data_be), .data_wdata_o(m_data_wdata), .data_rvalid_i(rvalid),
        .data_rdata_i(rdata), .data_err_i(derr), .rf_wdata_lsu_o(m_rf_wdata),
        .rf_we_lsu_o(m_rf_we), .lsu_resp_valid_o(m_resp_valid), .lsu_resp_err_o(m_resp_err)
    );

    int checks = 0;
    int errors = 0;

    // Observations from the last access
    int          obs_n;
    logic [31:0] obs_addr [2];
    logic [3:0]  obs_be [2];
    logic [31:0] obs_wd [2];
    logic        obs_we [2];
    logic        obs_stable, obs_ready, obs_timeout, obs_err, obs_rfwe;
    logic [31:0] obs_rfdata;

    // Model predictions
    int          exp_n;
    logic [31:0] exp_addr [2];
    logic [3:0]  exp_be [2];
    logic [31:0] exp_wd;
    logic        exp_err, exp_rfwe;
    logic [31:0] exp_rfdata;

    // Byte-level view: the access covers bytes addr..addr+size-1 of the 8-byte window formed by
    // the part-1 word and the next word.
    task automatic model_access(input logic support, input logic we, input logic [1:0] typ,
                                input logic sext, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic e0, input logic e1);
        int size, o, pos;
        logic mis;
        logic [63:0] win;
        logic [31:0] val;
        size = (typ == 2'b00) ? 4 : (typ == 2'b01) ? 2 : 1;
        o = int'(addr[1:0]);
        mis = (o + size) > 4;
        exp_addr[0] = {addr[31:2], 2'b00};
        exp_addr[1] = exp_addr[0] + 32'd4;
        exp_be[0] = 4'b0;
        exp_be[1] = 4'b0;
        for (int k = 0; k < size; k++) begin
            pos = o + k;
            if (pos < 4) exp_be[0][pos] = 1'b1;
            else exp_be[1][pos - 4] = 1'b1;
        end
        for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*((j - o + 4) % 4) +: 8];
        if (!support && mis) begin
            exp_n = 0; exp_err = 1'b1;
        end else if (mis && e0) begin
            exp_n = 1; exp_err = 1'b1;
        end else begin
            exp_n = mis ? 2 : 1; exp_err = mis ? e1 : e0;
        end
        win = {rd1, rd0};
        val = 32'h0;
        for (int k = 0; k < size; k++) val[8*k +: 8] = win[8*(o + k) +: 8];
        if (sext && size < 4 && val[8*size - 1]) begin
            for (int b = 8*size; b < 32; b++) val[b] = 1'b1;
        end
        exp_rfwe = !we && !exp_err;
        exp_rfdata = exp_rfwe ? val : 32'h0;
    endtask

    // Issues one access on the MisalignedSupport=1 unit and plays the bus slave.
    task automatic run_access(input logic we, input logic [1:0] typ, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int gd0, input int gd1, input int rv0, input int rv1,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input logic e0, input logic e1);
        int gd [2], rvd [2];
        logic [31:0] rd [2];
        logic er [2];
        int wcnt, rvcnt;
        logic waiting_rv, done, granting;
        gd[0] = gd0; gd[1] = gd1; rvd[0] = rv0; rvd[1] = rv1;
        rd[0] = rd0; rd[1] = rd1; er[0] = e0; er[1] = e1;
        @(negedge clk);
        gnt = 0; rvalid = 0; derr = 0;
        lsu_req = 1; lsu_we = we; lsu_type = typ; lsu_sext = sext;
        lsu_addr = addr; lsu_wdata = wd;
        #1 obs_ready = ready;
        obs_n = 0; obs_stable = 1; wcnt = 0; rvcnt = 0; waiting_rv = 0; done = 0;
        obs_err = 0; obs_rfwe = 0; obs_rfdata = 0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge clk);
            lsu_req = 0; gnt = 0; rvalid = 0; derr = 0; rdata = $urandom;
            lsu_addr = $urandom; lsu_wdata = $urandom; lsu_type = 2'($urandom);
            #1;
            if (data_req) begin
                if (wcnt == 0) begin
                    if (obs_n < 2) begin
                        obs_addr[obs_n] = data_addr; obs_be[obs_n] = data_be;
                        obs_wd[obs_n] = data_wdata; obs_we[obs_n] = data_we;
                    end
                end else if (obs_n < 2) begin
                    if (data_addr !== obs_addr[obs_n] || data_be !== obs_be[obs_n] ||
                        data_wdata !== obs_wd[obs_n] || data_we !== obs_we[obs_n])
                        obs_stable = 0;
                end
                granting = (obs_n < 2) ? (wcnt >= gd[obs_n]) : 1'b1;
                if (granting) begin
                    gnt = 1;
                    rvcnt = (obs_n < 2) ? rvd[obs_n] : 0;
                    waiting_rv = 1; obs_n++; wcnt = 0;
                end else begin
                    wcnt++;
                    // Responses outside a response phase must be ignored
                    if ($urandom % 3 == 0) begin rvalid = 1; derr = 1'($urandom); end
                end
            end else if (waiting_rv) begin
                if (rvcnt == 0) begin
                    rvalid = 1;
                    rdata = (obs_n <= 2) ? rd[obs_n - 1] : 32'h0;
                    derr = (obs_n <= 2) ? er[obs_n - 1] : 1'b0;
                    waiting_rv = 0;
                end else begin
                    rvcnt--;
                end
            end
            #1;
            if (resp_valid) begin
                obs_err = resp_err; obs_rfwe = rf_we; obs_rfdata = rf_wdata; done = 1;
            end
        end
        obs_timeout = !done;
    endtask

    task automatic test_access(input string name, input logic we, input logic [1:0] typ,
                               input logic sext, input logic [31:0] addr, input logic [31:0] wd,
                               input int gd0, input int gd1, input int rv0, input int rv1,
                               input logic [31:0] rd0, input logic [31:0] rd1,
                               input logic e0, input logic e1, input logic post);
        model_access(1'b1, we, typ, sext, addr, wd, rd0, rd1, e0, e1);
        run_access(we, typ, sext, addr, wd, gd0, gd1, rv0, rv1, rd0, rd1, e0, e1);
        checks++;
        if (obs_timeout !== 1'b0) begin
            errors++; $display("FAIL %s timeout: got no response, required one", name);
        end
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_at_accept: got %b required 1", name, obs_ready);
        end
        checks++;
        if (obs_n !== exp_n) begin
            errors++; $display("FAIL %s n_transactions: got %0d required %0d", name, obs_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < obs_n; i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_be[i] !== exp_be[i] || obs_we[i] !== we) begin
                errors++;
                $display("FAIL %s part%0d addr/be/we: got %h/%b/%b required %h/%b/%b", name, i + 1,
                         obs_addr[i], obs_be[i], obs_we[i], exp_addr[i], exp_be[i], we);
            end
            if (we) begin
                checks++;
                if (obs_wd[i] !== exp_wd) begin
                    errors++;
                    $display("FAIL %s part%0d wdata: got %h required %h", name, i + 1, obs_wd[i],
                             exp_wd);
                end
            end
        end
        checks++;
        if (obs_stable !== 1'b1) begin
            errors++; $display("FAIL %s req_stable: got changed request, required stable", name);
        end
        checks++;
        if (obs_err !== exp_err || obs_rfwe !== exp_rfwe || obs_rfdata !== exp_rfdata) begin
            errors++;
            $display("FAIL %s response err/rf_we/rf_wdata: got %b/%b/%h required %b/%b/%h", name,
                     obs_err, obs_rfwe, obs_rfdata, exp_err, exp_rfwe, exp_rfdata);
        end
        if (post) begin
            @(negedge clk);
            gnt = 0; rvalid = 0; derr = 0;
            #1;
            checks++;
            if (resp_valid !== 1'b0 || data_req !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL %s after_resp valid/req/ready: got %b/%b/%b required 0/0/1", name,
                         resp_valid, data_req, ready);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (ready !== 1'b1 || data_req !== 1'b0 || resp_valid !== 1'b0 || rf_we !== 1'b0 ||
            data_addr !== 32'h0 || data_be !== 4'h0 || data_we !== 1'b0 ||
            data_wdata !== 32'h0 || rf_wdata !== 32'h0 || m_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: ready=%b req=%b valid=%b rf_we=%b addr=%h be=%b required 1/0/0/0/0/0",
                     ready, data_req, resp_valid, rf_we, data_addr, data_be);
        end
        @(negedge clk);
        rvalid = 1; derr = 1; rdata = 32'h12345678;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_rvalid_ignored: got valid=%b err=%b required 0/0", resp_valid,
                     resp_err);
        end
        @(negedge clk);
        rvalid = 0; derr = 0;
    endtask

    task automatic test_directed();
        test_access("load_word_aligned", 0, 2'b00, 0, 32'h100, 32'h0, 0, 0, 1, 0,
                    32'hDEADBEEF, 32'h0, 0, 0, 1);
        checks++;
        if (obs_rfdata !== 32'hDEADBEEF || obs_rfwe !== 1'b1) begin
            errors++; $display("FAIL load_word_const: got %h required deadbeef", obs_rfdata);
        end
        test_access("load_half_signed", 0, 2'b01, 1, 32'h102, 32'h0, 0, 0, 0, 0,
                    32'h80010000, 32'h0, 0, 0, 1);
        checks++;
        if (obs_rfdata !== 32'hFFFF8001 || obs_be[0] !== 4'b1100) begin
            errors++;
            $display("FAIL load_half_signed_const: got %h be %b required ffff8001 be 1100",
                     obs_rfdata, obs_be[0]);
        end
        test_access("load_half_unsigned", 0, 2'b01, 0, 32'h102, 32'h0, 1, 0, 0, 0,
                    32'h80010000, 32'h0, 0, 0, 1);
        checks++;
        if (obs_rfdata !== 32'h00008001) begin
            errors++; $display("FAIL load_half_unsigned_const: got %h required 00008001",
                               obs_rfdata);
        end
        test_access("load_word_split", 0, 2'b00, 0, 32'h101, 32'h0, 0, 1, 1, 2,
                    32'h44332211, 32'h88776655, 0, 0, 1);
        checks++;
        if (obs_rfdata !== 32'h55443322 || obs_addr[1] !== 32'h104 || obs_be[1] !== 4'b0001) begin
            errors++;
            $display("FAIL load_word_split_const: got %h addr2 %h be2 %b required 55443322 104 0001",
                     obs_rfdata, obs_addr[1], obs_be[1]);
        end
        test_access("store_byte_gnt_delay", 1, 2'b10, 0, 32'h003, 32'h000000AB, 3, 0, 0, 0,
                    32'h0, 32'h0, 0, 0, 1);
        checks++;
        if (obs_wd[0][31:24] !== 8'hAB || obs_be[0] !== 4'b1000 || obs_rfwe !== 1'b0) begin
            errors++;
            $display("FAIL store_byte_const: got lane3 %h be %b rf_we %b required ab 1000 0",
                     obs_wd[0][31:24], obs_be[0], obs_rfwe);
        end
        test_access("split_store_err", 1, 2'b00, 0, 32'h202, 32'hCAFEF00D, 0, 0, 0, 0,
                    32'h0, 32'h0, 1, 0, 1);
        test_access("split_half_wrap", 0, 2'b01, 1, 32'hFFFFFFFF, 32'h0, 1, 2, 0, 1,
                    32'hF1000000, 32'h00000092, 0, 0, 1);
        test_access("split_word_err2", 0, 2'b00, 0, 32'h303, 32'h0, 0, 0, 0, 0,
                    32'h11111111, 32'h22222222, 0, 1, 1);
    endtask

    task automatic test_back_to_back();
        test_access("b2b_first", 0, 2'b00, 0, 32'h400, 32'h0, 0, 0, 0, 0,
                    32'h01020304, 32'h0, 0, 0, 0);
        test_access("b2b_second", 0, 2'b10, 1, 32'h405, 32'h0, 0, 0, 0, 0,
                    32'h0000F000, 32'h0, 0, 0, 0);
        test_access("b2b_third", 1, 2'b01, 0, 32'h407, 32'h00005A5A, 0, 0, 0, 0,
                    32'h0, 32'h0, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            test_access("random", 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                        $urandom, ($urandom % 5 == 0), ($urandom % 5 == 0), 1'($urandom));
        end
    endtask

    task automatic test_no_misaligned();
        logic [1:0] types [2] = '{2'b00, 2'b01};
        logic [31:0] addrs [2] = '{32'h501, 32'h603};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            gnt = 0; rvalid = 0; derr = 0;
            m_req = 1; lsu_we = 0; lsu_type = types[i]; lsu_addr = addrs[i]; lsu_sext = 0;
            #1;
            checks++;
            if (m_ready !== 1'b1 || m_data_req !== 1'b0) begin
                errors++; $display("FAIL nomis_accept ready/req: got %b/%b required 1/0",
                                   m_ready, m_data_req);
            end
            @(negedge clk);
            m_req = 0;
            #1;
            checks++;
            if (m_resp_valid !== 1'b1 || m_resp_err !== 1'b1 || m_rf_we !== 1'b0 ||
                m_data_req !== 1'b0) begin
                errors++;
                $display("FAIL nomis_resp valid/err/rf_we/req: got %b/%b/%b/%b required 1/1/0/0",
                         m_resp_valid, m_resp_err, m_rf_we, m_data_req);
            end
            @(negedge clk);
            #1;
            checks++;
            if (m_resp_valid !== 1'b0 || m_data_req !== 1'b0 || m_ready !== 1'b1) begin
                errors++;
                $display("FAIL nomis_after valid/req/ready: got %b/%b/%b required 0/0/1",
                         m_resp_valid, m_data_req, m_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int wait_cnt;
        @(negedge clk);
        gnt = 0; rvalid = 0; derr = 0;
        lsu_req = 1; lsu_we = 0; lsu_type = 2'b00; lsu_addr = 32'h700; lsu_sext = 0;
        @(negedge clk);
        lsu_req = 0;
        #1;
        wait_cnt = 0;
        while (!data_req && wait_cnt < 5) begin
            @(negedge clk);
            #1 wait_cnt++;
        end
        checks++;
        if (data_req !== 1'b1) begin
            errors++; $display("FAIL reset_mid_req: got %b required 1", data_req);
        end
        gnt = 1;
        @(negedge clk);
        gnt = 0; rst = 1;
        @(negedge clk);
        rst = 0; rvalid = 1; rdata = 32'hA5A5A5A5; derr = 0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || rf_we !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid valid/rf_we/ready: got %b/%b/%b required 0/0/1", resp_valid,
                     rf_we, ready);
        end
        @(negedge clk);
        rvalid = 0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || data_req !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after valid/req/ready: got %b/%b/%b required 0/0/1",
                     resp_valid, data_req, ready);
        end
    endtask

    initial begin
        rst = 1; lsu_req = 0; m_req = 0; lsu_we = 0; lsu_sext = 0; lsu_type = 0;
        lsu_addr = 0; lsu_wdata = 0; gnt = 0; rvalid = 0; derr = 0; rdata = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_no_misaligned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
